dram_stream_model: RTL and testbench
====================================

# dram_stream_model

Parametrised main-memory timing model for simulation, sitting on the L2 miss side of `System` in place of the fixed-latency memory. Its new features over the fixed model are multiple outstanding reads through a request queue, configurable geometry and latencies, and an optional critical-subblock-first return order. Reads return a whole block as `SUBBLOCKS` back-to-back beats tagged by strobe. Writes arrive as tagged beats and close the write port for a programmable recovery time.

## Interface
- `ADDR_BITS`, 32, byte address width
- `BLOCK_BITS`, 512, cache block width; power of two, at least 64
- `SUBBLOCKS`, 4, beats per block; power of two, at least 2
- `MEM_BLOCKS`, 4096, array depth in blocks; power of two
- `READ_LAT`, 5, cycles from read acceptance to first beat; at least 1
- `WRITE_LAT`, 10, write recovery cycles after the final write beat; at least 1
- `RQ_DEPTH`, 4, outstanding read requests; power of two, at least 1
- `CRIT_FIRST`, 0, when 1, beat order starts at the subblock containing `addr`
- `INIT_FILE`, "", hex image loaded at time 0 when non-empty (simulation only)
- `clk` in 1: single clock; all state changes on rising edge
- `reset` in 1: asynchronous, active-high
- `addr` in `ADDR_BITS`: byte address of a read request or write beat
- `en` in 1: read request; valid only when `we`=0
- `we` in 1: write beat
- `dinDstrobe` in log2(`SUBBLOCKS`): subblock index of the write beat
- `din` in `BLOCK_BITS`/`SUBBLOCKS`: write beat data
- `doutDstrobe` out log2(`SUBBLOCKS`): subblock index of the read beat
- `dout` out `BLOCK_BITS`/`SUBBLOCKS`: read beat data
- `dready` out 1: read beat valid this cycle
- `accR` out 1: read request will be accepted
- `accW` out 1: write port open

## Operation
- Block index = (`addr` >> log2(`BLOCK_BITS`/8)) mod `MEM_BLOCKS`. Subblock of `addr` = next log2(`SUBBLOCKS`) address bits.
- Read acceptance:
  - Condition: `en`=1, `we`=0, `accR`=1.
  - The accepted entry holds: snapshot of the full block as it stands after this edge's array update, start subblock (the subblock of `addr` if `CRIT_FIRST`, else 0), and a countdown loaded with `READ_LAT`-1.
  - `en` with `accR`=0 is ignored; no error.
  - `accR` = queue not full (combinational).
- Countdowns: every queued entry with countdown > 0 decrements each cycle, head included.
- Streamer states:
  - IDLE → STREAM when the queue is non-empty and the head countdown = 0.
  - STREAM emits `SUBBLOCKS` consecutive beats. Beat k carries subblock (start+k) mod `SUBBLOCKS`, wrapping around. `doutDstrobe` equals that index; `dready`=1.
  - After the last beat, the head is popped. If the new head countdown = 0, the next train starts the very next cycle with no bubble; otherwise go to IDLE.
  - Pop and acceptance in the same cycle with a full queue: acceptance is still refused. `accR` reflects the pre-edge occupancy.
- Write beat (`we`=1):
  - Updates subblock `dinDstrobe` of the addressed block at the edge.
  - `en` is ignored when `we`=1.
  - Beats of one block are issued in any order. Writes are checked against `accW` only before the first beat.
  - A beat with `dinDstrobe`=`SUBBLOCKS`-1 loads the recovery counter with `WRITE_LAT`.
  - `accW` = (recovery counter = 0). The counter decrements each cycle to 0.
- Read/write ordering: a read sees every write beat completed at or before its acceptance edge. Later writes never alter queued snapshots.
- Reset (asynchronous):
  - Clears the queue, the streamer (to IDLE), the recovery counter, `dready`, `doutDstrobe` and `dout` to 0.
  - Array contents are preserved.
  - Asserting reset mid-stream aborts the train. No further beats are produced for that request.

## Timing
- `dout`, `doutDstrobe` and `dready` are registered.
- Reset values: `dready`=0, `doutDstrobe`=0, `dout`=0, `accR`=1, `accW`=1.
- Isolated read accepted at edge t: beats at edges t+`READ_LAT` … t+`READ_LAT`+`SUBBLOCKS`-1.
- Reads accepted at consecutive edges t, t+1: the second train starts at t+`READ_LAT`+`SUBBLOCKS`, contiguous with the first. Bus occupancy is the only serialisation.
- Final write beat at edge t: `accW`=0 from t through t+`WRITE_LAT`-1, and 1 again after edge t+`WRITE_LAT`.
- Sustained read throughput: one block per `SUBBLOCKS` cycles.

## Test plan
- Defaults, preload block 3 with beats A,B,C,D. Read addr 0xC0 at edge 10 → `dready` at edges 15–18, strobes 0,1,2,3, data A,B,C,D.
- `CRIT_FIRST`=1, read addr 0xE0 (subblock 2) → strobes 2,3,0,1 with matching data.
- Issue 5 reads on consecutive cycles with `RQ_DEPTH`=4 → `accR` drops after the 4th and the 5th is ignored. Trains run back-to-back with 16 contiguous `dready` cycles and no bubbles.
- Write 4 beats to block 7, final beat at edge 20 → `accW`=0 for edges 20–29. A read of block 7 accepted at edge 21 returns the new data. A read accepted before edge 17 returns the old data.
- Assert `reset` asynchronously mid-train after beat 1 → `dready`, `doutDstrobe` and `dout` go to 0 immediately. `accR`=`accW`=1. No further beats; the array is retained, so a re-read returns the same data.
- Simultaneous `en`=1 and `we`=1 → the write is performed and no read is queued; queue occupancy is unchanged.

Source files
------------

// File: rtl/dram_stream_model.sv
// dram_stream_model: main-memory timing model with a read request queue,
// whole-block beat trains per read and write recovery gating.
module dram_stream_model #(
  parameter int    ADDR_BITS  = 32,
  parameter int    BLOCK_BITS = 512,
  parameter int    SUBBLOCKS  = 4,
  parameter int    MEM_BLOCKS = 4096,
  parameter int    READ_LAT   = 5,
  parameter int    WRITE_LAT  = 10,
  parameter int    RQ_DEPTH   = 4,
  parameter int    CRIT_FIRST = 0,
  parameter string INIT_FILE  = "",
  localparam int   SW = $clog2(SUBBLOCKS),
  localparam int   BW = BLOCK_BITS / SUBBLOCKS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic                 en,
  input  logic                 we,
  input  logic [SW-1:0]        dinDstrobe,
  input  logic [BW-1:0]        din,
  output logic [SW-1:0]        doutDstrobe,
  output logic [BW-1:0]        dout,
  output logic                 dready,
  output logic                 accR,
  output logic                 accW
);

  localparam int OFFB = $clog2(BLOCK_BITS / 8);
  localparam int IB   = (MEM_BLOCKS > 1) ? $clog2(MEM_BLOCKS) : 1;
  localparam int PW   = (RQ_DEPTH > 1) ? $clog2(RQ_DEPTH) : 1;
  localparam int NW   = $clog2(RQ_DEPTH + 1);
  localparam int CW   = $clog2(READ_LAT + 1);
  localparam int WW   = $clog2(WRITE_LAT + 1);

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  logic [BLOCK_BITS-1:0] r_mem [MEM_BLOCKS];
  logic [BLOCK_BITS-1:0] r_snap [RQ_DEPTH];
  logic [SW-1:0]         r_start [RQ_DEPTH];
  logic [CW-1:0]         r_cd [RQ_DEPTH];
  logic [PW-1:0]         r_wp, r_rp;
  logic [NW-1:0]         r_cnt;
  logic [WW-1:0]         r_wrec;
  state_t                r_state, w_state_nx;
  logic [SW-1:0]         r_beat, w_beat_nx;
  logic [SW-1:0]         r_dstb;
  logic [BW-1:0]         r_dout;
  logic                  r_dready;

  logic [IB-1:0] w_blk;
  logic [SW-1:0] w_sub;
  logic [SW-1:0] w_idx;
  logic [PW-1:0] w_wp_nx, w_rp_nx;
  logic          w_acc, w_head_rdy, w_emit, w_pop;
  logic          w_unused;

  assign w_unused = ^addr;
  assign w_blk = (MEM_BLOCKS > 1) ? addr[OFFB +: IB] : '0;
  assign w_sub = (CRIT_FIRST != 0) ? addr[OFFB-1 -: SW] : '0;

  assign accR  = (r_cnt != NW'(RQ_DEPTH));
  assign accW  = (r_wrec == '0);
  assign w_acc = en && !we && accR;

  assign w_wp_nx = (r_wp == PW'(RQ_DEPTH - 1)) ? '0 : r_wp + 1'b1;
  assign w_rp_nx = (r_rp == PW'(RQ_DEPTH - 1)) ? '0 : r_rp + 1'b1;

  assign w_head_rdy = (r_cnt != '0) && (r_cd[r_rp] == '0);
  assign w_idx      = r_start[r_rp] + r_beat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_beat  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_beat  <= w_beat_nx;
    end
  end

  // IDLE launches beat 0 on the same edge it leaves, so back-to-back
  // trains pass through IDLE for one cycle without a bus bubble.
  always_comb begin
    w_state_nx = r_state;
    w_beat_nx  = r_beat;
    w_emit     = 1'b0;
    w_pop      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_head_rdy) begin
          w_emit     = 1'b1;
          w_beat_nx  = SW'(1);
          w_state_nx = S_STREAM;
        end
      end
      S_STREAM: begin
        w_emit = 1'b1;
        if (r_beat == SW'(SUBBLOCKS - 1)) begin
          w_pop      = 1'b1;
          w_beat_nx  = '0;
          w_state_nx = S_IDLE;
        end else begin
          w_beat_nx = r_beat + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < RQ_DEPTH; i++) r_cd[i] <= '0;
    end else begin
      for (int i = 0; i < RQ_DEPTH; i++) begin
        if (r_cd[i] != '0) r_cd[i] <= r_cd[i] - 1'b1;
      end
      if (w_acc) begin
        r_cd[r_wp] <= CW'(READ_LAT - 1);
        r_wp       <= w_wp_nx;
      end
      if (w_pop) r_rp <= w_rp_nx;
      r_cnt <= r_cnt + NW'(w_acc) - NW'(w_pop);
    end
  end

  // Array and snapshots survive reset; a read never coincides with a write.
  always_ff @(posedge clk) begin
    if (we) r_mem[w_blk][dinDstrobe*BW +: BW] <= din;
    if (w_acc) begin
      r_snap[r_wp]  <= r_mem[w_blk];
      r_start[r_wp] <= w_sub;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dready <= 1'b0;
      r_dstb   <= '0;
      r_dout   <= '0;
    end else begin
      r_dready <= w_emit;
      if (w_emit) begin
        r_dstb <= w_idx;
        r_dout <= r_snap[r_rp][w_idx*BW +: BW];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrec <= '0;
    end else if (we && dinDstrobe == SW'(SUBBLOCKS - 1)) begin
      r_wrec <= WW'(WRITE_LAT);
    end else if (r_wrec != '0) begin
      r_wrec <= r_wrec - 1'b1;
    end
  end

  assign dready      = r_dready;
  assign doutDstrobe = r_dstb;
  assign dout        = r_dout;

endmodule

// File: tb/tb_dram_stream_model.sv
// tb_dram_stream_model: scoreboard bench for the DRAM stream model:
// read trains, critical-first order, queue limit, writes and reset.
`timescale 1ns/1ps
module tb_dram_stream_model;
  localparam int BW = 128;
  localparam int RL = 5;
  localparam int WL = 10;
  localparam int NS = 4;
  localparam int QD = 4;

  typedef struct {
    int            cyc;
    logic [1:0]    stb;
    logic [BW-1:0] data;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   addr = '0;
  logic          en = 1'b0;
  logic          we = 1'b0;
  logic [1:0]    dinDstrobe = '0;
  logic [BW-1:0] din = '0;
  logic [1:0]    doutDstrobe, c_stb;
  logic [BW-1:0] dout, c_dout;
  logic          dready, accR, accW;
  logic          c_dready, c_accR, c_accW;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int bus_free = 0;
  beat_t exp_q[$];
  beat_t crit_q[$];
  int pend_end[$];
  logic [511:0] model [int];

  dram_stream_model u_dut (
    .clk(clk), .reset(reset), .addr(addr), .en(en), .we(we),
    .dinDstrobe(dinDstrobe), .din(din),
    .doutDstrobe(doutDstrobe), .dout(dout), .dready(dready),
    .accR(accR), .accW(accW)
  );

  dram_stream_model #(.CRIT_FIRST(1)) u_crit (
    .clk(clk), .reset(reset), .addr(addr), .en(en), .we(we),
    .dinDstrobe(dinDstrobe), .din(din),
    .doutDstrobe(c_stb), .dout(c_dout), .dready(c_dready),
    .accR(c_accR), .accW(c_accW)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle();
    en = 1'b0;
    we = 1'b0;
  endtask

  // Read hitting the edge after the current negedge; models queue and bus.
  task automatic drive_read(input logic [31:0] a, output bit acc);
    int e, st, blk, s1;
    e = cyc + 1;
    while (pend_end.size() > 0 && pend_end[0] < e) void'(pend_end.pop_front());
    addr = a;
    en = 1'b1;
    we = 1'b0;
    acc = (pend_end.size() < QD);
    if (acc) begin
      blk = (a >> 6) % 4096;
      st = (e + RL > bus_free) ? e + RL : bus_free;
      for (int j = 0; j < NS; j++) begin
        s1 = (int'(a[5:4]) + j) % NS;
        exp_q.push_back('{st + j, 2'(j), model[blk][j*BW +: BW]});
        crit_q.push_back('{st + j, 2'(s1), model[blk][s1*BW +: BW]});
      end
      bus_free = st + NS;
      pend_end.push_back(st + NS - 1);
    end
  endtask

  task automatic drive_write(input logic [31:0] a, input int s,
                             input logic [BW-1:0] d, input bit en_too);
    int blk;
    blk = (a >> 6) % 4096;
    addr = a;
    we = 1'b1;
    en = en_too;
    dinDstrobe = 2'(s);
    din = d;
    model[blk][s*BW +: BW] = d;
  endtask

  function automatic logic [BW-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if (dready !== 1'b0) begin
      errors++; $display("FAIL rst_dready got=%b want=0", dready);
    end
    checks++;
    if (doutDstrobe !== 2'd0) begin
      errors++; $display("FAIL rst_strobe got=%0d want=0", doutDstrobe);
    end
    checks++;
    if (dout !== '0) begin
      errors++; $display("FAIL rst_dout got=%h want=0", dout);
    end
    checks++;
    if (accR !== 1'b1 || c_accR !== 1'b1) begin
      errors++; $display("FAIL rst_accR got=%b/%b want=1", accR, c_accR);
    end
    checks++;
    if (accW !== 1'b1 || c_accW !== 1'b1) begin
      errors++; $display("FAIL rst_accW got=%b/%b want=1", accW, c_accW);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic preload();
    for (int k = 0; k < 8; k++) begin
      drive_write((k < 4) ? 32'h0C0 : 32'h1C0, k % 4, rnd(), 1'b0);
      tick();
    end
    idle();
    repeat (WL + 2) tick();
  endtask

  task automatic test_read_basic();
    beat_t b;
    bit acc;
    for (int k = 0; k < 14; k++) begin
      idle();
      if (k == 0) drive_read(32'h0C0, acc);
      tick();
      if (dready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL basic_beat cyc=%0d unexpected beat stb=%0d", cyc, doutDstrobe);
        end else begin
          b = exp_q.pop_front();
          if (cyc != b.cyc || doutDstrobe !== b.stb || dout !== b.data) begin
            errors++;
            $display("FAIL basic_beat cyc=%0d stb=%0d dout=%h want cyc=%0d stb=%0d dout=%h",
                     cyc, doutDstrobe, dout, b.cyc, b.stb, b.data);
          end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL basic_missing got=%0d left want=0", exp_q.size());
    end
    exp_q.delete();
    crit_q.delete();
  endtask

  task automatic test_crit_first();
    beat_t b;
    bit acc;
    for (int k = 0; k < 14; k++) begin
      idle();
      if (k == 0) drive_read(32'h0E0, acc);
      tick();
      if (c_dready) begin
        checks++;
        if (crit_q.size() == 0) begin
          errors++; $display("FAIL crit_beat cyc=%0d unexpected beat stb=%0d", cyc, c_stb);
        end else begin
          b = crit_q.pop_front();
          if (cyc != b.cyc || c_stb !== b.stb || c_dout !== b.data) begin
            errors++;
            $display("FAIL crit_beat cyc=%0d stb=%0d dout=%h want cyc=%0d stb=%0d dout=%h",
                     cyc, c_stb, c_dout, b.cyc, b.stb, b.data);
          end
        end
      end
    end
    checks++;
    if (crit_q.size() != 0) begin
      errors++; $display("FAIL crit_missing got=%0d left want=0", crit_q.size());
    end
    exp_q.delete();
    crit_q.delete();
  endtask

  task automatic test_back_to_back();
    beat_t b;
    bit acc;
    int nrdy;
    nrdy = 0;
    for (int k = 0; k < 30; k++) begin
      idle();
      if (k < 5) begin
        drive_read((k % 2 == 0) ? 32'h0C0 : 32'h1C0, acc);
        checks++;
        if (accR !== acc) begin
          errors++; $display("FAIL b2b_accR read=%0d got=%b want=%b", k, accR, acc);
        end
      end
      tick();
      if (dready) begin
        nrdy++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_beat cyc=%0d unexpected beat stb=%0d", cyc, doutDstrobe);
        end else begin
          b = exp_q.pop_front();
          if (cyc != b.cyc || doutDstrobe !== b.stb || dout !== b.data) begin
            errors++;
            $display("FAIL b2b_beat cyc=%0d stb=%0d dout=%h want cyc=%0d stb=%0d dout=%h",
                     cyc, doutDstrobe, dout, b.cyc, b.stb, b.data);
          end
        end
      end
    end
    checks++;
    if (nrdy != 4 * NS || exp_q.size() != 0) begin
      errors++; $display("FAIL b2b_count got=%0d beats want=%0d", nrdy, 4 * NS);
    end
    exp_q.delete();
    crit_q.delete();
  endtask

  task automatic test_write();
    beat_t b;
    bit acc;
    int t_last;
    logic [BW-1:0] nd [4];
    bit exp_w;
    t_last = -100;
    for (int j = 0; j < 4; j++) nd[j] = rnd();
    for (int k = 0; k < 30; k++) begin
      idle();
      if (k == 0 || k == 5) drive_read(32'h1C0, acc);
      if (k >= 1 && k <= 4) drive_write(32'h1C0, k - 1, nd[k-1], 1'b0);
      tick();
      if (k == 4) t_last = cyc;
      exp_w = !(cyc >= t_last && cyc < t_last + WL);
      checks++;
      if (accW !== exp_w) begin
        errors++; $display("FAIL wr_accW cyc=%0d got=%b want=%b", cyc, accW, exp_w);
      end
      if (dready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL wr_beat cyc=%0d unexpected beat stb=%0d", cyc, doutDstrobe);
        end else begin
          b = exp_q.pop_front();
          if (cyc != b.cyc || doutDstrobe !== b.stb || dout !== b.data) begin
            errors++;
            $display("FAIL wr_beat cyc=%0d stb=%0d dout=%h want cyc=%0d stb=%0d dout=%h",
                     cyc, doutDstrobe, dout, b.cyc, b.stb, b.data);
          end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL wr_missing got=%0d left want=0", exp_q.size());
    end
    exp_q.delete();
    crit_q.delete();
  endtask

  task automatic test_reset_mid();
    beat_t b;
    bit acc;
    int krst;
    krst = -1;
    for (int k = 0; k < 40; k++) begin
      idle();
      if (k == 0 || (krst >= 0 && k == krst + 12)) drive_read(32'h0C0, acc);
      tick();
      if (dready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rmid_beat cyc=%0d unexpected beat stb=%0d", cyc, doutDstrobe);
        end else begin
          b = exp_q.pop_front();
          if (cyc != b.cyc || doutDstrobe !== b.stb || dout !== b.data) begin
            errors++;
            $display("FAIL rmid_beat cyc=%0d stb=%0d dout=%h want cyc=%0d stb=%0d dout=%h",
                     cyc, doutDstrobe, dout, b.cyc, b.stb, b.data);
          end
          if (krst < 0 && b.stb == 2'd1) begin
            krst = k;
            #2 reset = 1'b1;
            #1;
            checks++;
            if (dready !== 1'b0 || doutDstrobe !== 2'd0 || dout !== '0) begin
              errors++;
              $display("FAIL rmid_outs got dready=%b stb=%0d dout=%h want 0/0/0",
                       dready, doutDstrobe, dout);
            end
            checks++;
            if (accR !== 1'b1 || accW !== 1'b1) begin
              errors++; $display("FAIL rmid_acc got accR=%b accW=%b want 1/1", accR, accW);
            end
            #1 reset = 1'b0;
            exp_q.delete();
            crit_q.delete();
            pend_end.delete();
            bus_free = 0;
          end
        end
      end
    end
    checks++;
    if (krst < 0 || exp_q.size() != 0) begin
      errors++; $display("FAIL rmid_end got krst=%0d left=%0d want reset and 0 left", krst, exp_q.size());
    end
    exp_q.delete();
    crit_q.delete();
  endtask

  task automatic test_en_we();
    beat_t b;
    bit acc;
    for (int k = 0; k < 20; k++) begin
      idle();
      if (k == 0) drive_write(32'h0C0, 0, rnd(), 1'b1);
      if (k == 4) drive_read(32'h0C0, acc);
      tick();
      if (dready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL enwe_beat cyc=%0d unexpected beat stb=%0d", cyc, doutDstrobe);
        end else begin
          b = exp_q.pop_front();
          if (cyc != b.cyc || doutDstrobe !== b.stb || dout !== b.data) begin
            errors++;
            $display("FAIL enwe_beat cyc=%0d stb=%0d dout=%h want cyc=%0d stb=%0d dout=%h",
                     cyc, doutDstrobe, dout, b.cyc, b.stb, b.data);
          end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL enwe_missing got=%0d left want=0", exp_q.size());
    end
    exp_q.delete();
    crit_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d want finish before timeout", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    test_reset();
    preload();
    test_read_basic();
    test_crit_first();
    test_back_to_back();
    test_write();
    test_reset_mid();
    test_en_we();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
